// File: rtl/ddr_pkg.sv
// ddr_pkg: shared DDR3 / MIG user-interface constants and the arbiter
// state encoding.
//   CMD_WR / CMD_RD   MIG app_cmd encodings
//   DDR_*_W           MIG UI address, data and mask widths
//   arb_state_e       arbiter FSM states
package ddr_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int DDR_ADDR_W = 28;
  localparam int DDR_DATA_W = 128;
  localparam int DDR_MASK_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ddr3_mport_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
// The search starts at ptr_i when mode_i=1, or at port 0 when mode_i=0.
// The first asserted request found wins.
//   req_i    per-port request vector
//   ptr_i    index where the round-robin search starts
//   mode_i   1 = rotate from ptr_i, 0 = fixed priority (port 0 highest)
//   valid_o  at least one request is asserted
//   idx_o    index of the winning port (0 when valid_o=0)
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  logic                 mode_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o
);

  int   base;
  int   cand;
  logic found;

  always_comb begin
    found   = 1'b0;
    idx_o   = '0;
    cand    = 0;
    base    = mode_i ? int'(ptr_i) : 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = base + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ddr3_mport_arbiter.sv
// ddr3_mport_arbiter: N-port arbiter and MIG UI command mux (ui_clk domain).
// One command engine is granted at a time. The grant is held until that
// engine's end pulse, or until the watchdog expires. Only the owner's
// app_* command fields reach the MIG.
//   sclk, rst          ui_clk; synchronous active-high reset
//   req                per-port level request
//   end_i              per-port burst-complete pulse (only the owner's counts)
//   start              one-hot, single-cycle grant pulse
//   eng_app_*          per-engine MIG command fields, packed per port
//   app_en/cmd/addr    muxed command to the MIG (zero when not busy)
//   busy               grant held
//   grant_id           current or last owner
//   timeout_err        single-cycle pulse when the watchdog forces a release
//
// state    | meaning
// ARB_IDLE | no owner; a grant is issued as soon as any request is seen
// ARB_BUSY | grant_id owns the MIG port until its end pulse or the watchdog
module ddr3_mport_arbiter
  import ddr_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = DDR_ADDR_W,
  parameter int CMD_W     = 3,
  parameter int RR_MODE   = 1,
  parameter int MAX_HOLD  = 4096
) (
  input  logic                        sclk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        end_i,
  output logic [NUM_PORTS-1:0]        start,
  input  logic [NUM_PORTS-1:0]        eng_app_en,
  input  logic [NUM_PORTS*CMD_W-1:0]  eng_app_cmd,
  input  logic [NUM_PORTS*ADDR_W-1:0] eng_app_addr,
  output logic                        app_en,
  output logic [CMD_W-1:0]            app_cmd,
  output logic [ADDR_W-1:0]           app_addr,
  output logic                        busy,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                        timeout_err
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] start_q, start_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     ptr_q,   ptr_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 to_q,    to_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     ptr_next;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .mode_i  (RR_MODE != 0),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // The next search starts just after whoever is releasing the port.
  assign ptr_next = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    start_d = '0;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d           = ARB_BUSY;
          start_d[pick_idx] = 1'b1;
          grant_d           = pick_idx;
          cnt_d             = '0;
        end
      end
      ARB_BUSY: begin
        // A real end wins over a coincident watchdog expiry.
        if (end_i[grant_q]) begin
          state_d = ARB_IDLE;
          ptr_d   = ptr_next;
        end else if ((MAX_HOLD > 0) && (cnt_q == HOLD_LAST)) begin
          state_d = ARB_IDLE;
          ptr_d   = ptr_next;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      start_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign start       = start_q;
  assign busy        = (state_q == ARB_BUSY);
  assign grant_id    = grant_q;
  assign timeout_err = to_q;

  // Non-owner engines never reach the MIG; app_rdy is not gated here.
  always_comb begin
    app_en   = 1'b0;
    app_cmd  = '0;
    app_addr = '0;
    if (busy) begin
      app_en   = eng_app_en[grant_q];
      app_cmd  = eng_app_cmd[grant_q*CMD_W +: CMD_W];
      app_addr = eng_app_addr[grant_q*ADDR_W +: ADDR_W];
    end
  end

endmodule
